// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//
// Pipeline register between decode and execute. It captures one decoded
// instruction per valid/ready handshake and drives the ALU S, T and Ctr
// inputs from registered state. RAW hazards are resolved by forwarding from
// the EX/MEM and MEM/WB result buses. Forwarding happens at capture, and it
// also happens while a held instruction is stalled ("hold-snoop"), so the
// operands stay coherent with writes that retire during the stall.
//
// Handshake: a transfer happens on an edge where valid && ready are both 1.
// in_ready = !out_valid || out_ready. This lets capture and consume occur in
// the same cycle, and lets the stage refill when it is empty. The producer
// must keep its payload stable while valid && !ready. Flush does not touch
// in_ready, so decode sees its handshake complete and must drop the
// instruction itself.
//
// Ports:
//   clk, reset                          clock, async active-high reset
//   in_valid / in_ready                 decode -> stage handshake
//   in_rs_addr, in_rt_addr, in_rd_addr  source/destination registers
//   in_rs_data, in_rt_data, in_imm      operand sources
//   in_alu_src, in_alu_ctr, in_reg_write  decoded control
//   flush                               discard held or incoming instruction
//   exm_*, wb_*                         EX/MEM and MEM/WB forwarding buses
//   out_valid / out_ready               stage -> execute handshake
//   alu_s, alu_t, alu_ctr               registered ALU inputs
//   out_rd_addr, out_reg_write          registered destination / write enable
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_rs_addr,
    input  logic [AW-1:0] in_rt_addr,
    input  logic [AW-1:0] in_rd_addr,
    input  logic [DW-1:0] in_rs_data,
    input  logic [DW-1:0] in_rt_data,
    input  logic [DW-1:0] in_imm,
    input  logic          in_alu_src,
    input  logic [2:0]    in_alu_ctr,
    input  logic          in_reg_write,
    input  logic          flush,
    input  logic          exm_reg_write,
    input  logic [AW-1:0] exm_rd_addr,
    input  logic [DW-1:0] exm_result,
    input  logic          wb_reg_write,
    input  logic [AW-1:0] wb_rd_addr,
    input  logic [DW-1:0] wb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] alu_s,
    output logic [DW-1:0] alu_t,
    output logic [2:0]    alu_ctr,
    output logic [AW-1:0] out_rd_addr,
    output logic          out_reg_write
);

    // Latched source addresses and operand select, used for hold-snoop.
    logic [AW-1:0] held_rs;
    logic [AW-1:0] held_rt;
    logic          held_alu_src;

    logic capture;
    logic consume;
    logic hold;

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign consume  = out_valid && out_ready;
    assign hold     = out_valid && !out_ready && !flush;

    // Register 0 reads as zero. EX/MEM is the younger result, so it wins
    // over MEM/WB.
    function automatic logic [DW-1:0] fwd(input logic [AW-1:0] addr,
                                          input logic [DW-1:0] regdata);
        logic [DW-1:0] r;
        if (addr == '0)
            r = '0;
        else if (exm_reg_write && exm_rd_addr == addr)
            r = exm_result;
        else if (wb_reg_write && wb_rd_addr == addr)
            r = wb_data;
        else
            r = regdata;
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            alu_s         <= '0;
            alu_t         <= '0;
            alu_ctr       <= '0;
            out_rd_addr   <= '0;
            out_reg_write <= 1'b0;
            held_rs       <= '0;
            held_rt       <= '0;
            held_alu_src  <= 1'b0;
        end else if (flush) begin
            // Data registers keep their values. Only validity and the write
            // enable drop.
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
        end else if (capture) begin
            out_valid     <= 1'b1;
            alu_s         <= fwd(in_rs_addr, in_rs_data);
            alu_t         <= in_alu_src ? in_imm : fwd(in_rt_addr, in_rt_data);
            alu_ctr       <= in_alu_ctr;
            out_rd_addr   <= in_rd_addr;
            out_reg_write <= in_reg_write;
            held_rs       <= in_rs_addr;
            held_rt       <= in_rt_addr;
            held_alu_src  <= in_alu_src;
        end else if (consume) begin
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
        end else if (hold) begin
            // A stalled operand picks up any result for its source register
            // that retires while it waits. An immediate T operand never changes.
            alu_s <= fwd(held_rs, alu_s);
            if (!held_alu_src)
                alu_t <= fwd(held_rt, alu_t);
        end
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register that sits directly upstream of the 3-bit-`Ctr` ALU in the pipelined CPU, between decode and execute. It captures one decoded instruction per handshake: source operands, immediate, ALU control, and destination. It resolves RAW hazards by forwarding from the EX/MEM and MEM/WB result buses, and drives the ALU `S`, `T` and `Ctr` inputs from registered state. The stage supports downstream back-pressure and flush, and keeps held operands coherent while stalled.

## Interface
- `DW`, 32: datapath width (ALU operand width)
- `AW`, 5: register address width; address 0 is the hardwired-zero register
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  decode presents an instruction
- `in_ready`  out  1  stage accepts this cycle; equals `!out_valid || out_ready`
- `in_rs_addr`, `in_rt_addr`, `in_rd_addr`  in  AW  source/destination register numbers
- `in_rs_data`, `in_rt_data`  in  DW  register-file read data
- `in_imm`  in  DW  sign/zero-extended immediate
- `in_alu_src`  in  1  1: T operand is `in_imm`; 0: T operand is rt
- `in_alu_ctr`  in  3  ALU operation code, passed through unchanged
- `in_reg_write`  in  1  instruction writes `in_rd_addr`
- `flush`  in  1  discard held or incoming instruction
- `exm_reg_write`, `exm_rd_addr`, `exm_result`  in  1/AW/DW  EX/MEM forwarding source
- `wb_reg_write`, `wb_rd_addr`, `wb_data`  in  1/AW/DW  MEM/WB forwarding source
- `out_valid`  out  1  ALU operands valid
- `out_ready`  in  1  execute stage consumes this cycle
- `alu_s`, `alu_t`  out  DW  registered ALU operands S, T
- `alu_ctr`  out  3  registered ALU control
- `out_rd_addr`  out  AW  registered destination
- `out_reg_write`  out  1  registered write enable; forced 0 when `out_valid`=0

## Operation
- Reset sets every register to 0: `out_valid`=0, `alu_s`=`alu_t`=0, `alu_ctr`=0, `out_rd_addr`=0, `out_reg_write`=0, held rs/rt addresses=0, held `alu_src`=0. `in_ready`=1 immediately.
- Forward function fwd(addr, regdata):
  - addr==0 -> 0.
  - else `exm_reg_write && exm_rd_addr==addr` -> `exm_result`.
  - else `wb_reg_write && wb_rd_addr==addr` -> `wb_data`.
  - else regdata.
  - EX/MEM has priority over MEM/WB when both match.
- Capture occurs when `in_valid && in_ready && !flush`:
  - `alu_s` <= fwd(rs, `in_rs_data`).
  - `alu_t` <= `in_alu_src` ? `in_imm` : fwd(rt, `in_rt_data`).
  - Control, dest, rs/rt addresses and `alu_src` are latched.
  - `out_valid` <= 1.
- Consume without capture (`out_valid && out_ready`, no capture): `out_valid` <= 0; data registers keep their values.
- Hold-snoop applies when `out_valid && !out_ready && !flush`. Each held operand whose latched source address matches a forwarding bus is overwritten:
  - `alu_s` <= fwd(held_rs, `alu_s`).
  - `alu_t` <= held_alu_src ? `alu_t` : fwd(held_rt, `alu_t`).
  - Priority is the same as at capture.
- Flush has highest priority: `out_valid` <= 0 and no capture in that cycle. `in_ready` is unaffected by flush, so decode sees its handshake complete and must drop the instruction itself.
- Arithmetic: none; no width changes. The immediate is used as supplied.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N appears on `alu_*` with `out_valid`=1 after edge N.
- Throughput: 1 per cycle while `out_ready`=1 (capture and consume occur in the same cycle).
- `in_ready` is combinational from `out_valid` and `out_ready`. Every other output is purely registered.
- Forwarding buses are sampled at the capture or snoop edge only.
- Reset asserted mid-hold drops the instruction asynchronously. `out_valid` falls within the reset assertion, not at the next edge.

## Test plan
- Back-to-back: rs=1 (data 5), rt=2 (data 7), ctr=001, alu_src=0, three instrs with `out_ready`=1 -> `alu_s`=5, `alu_t`=7 one cycle after each accept; `out_valid` continuously 1.
- Dual forward priority: rs=3, `exm_rd_addr`=3 `exm_result`=0xAA, `wb_rd_addr`=3 `wb_data`=0xBB, both writes=1 -> `alu_s`=0xAA. Repeat with rs=0 -> `alu_s`=0.
- Stall snoop: capture rt=4 (data 1), hold `out_ready`=0 two cycles, in second cycle `wb_reg_write`=1 rd=4 data=0x55 -> `alu_t`=0x55, `in_ready`=0 throughout. Repeat with alu_src=1, imm=9 -> `alu_t` stays 9.
- Flush vs capture: `in_valid`=1 and `flush`=1 same cycle -> `out_valid`=0 next cycle, `out_reg_write`=0.
- Async reset mid-hold: `out_valid`=1, `out_ready`=0, assert `reset` between edges -> `out_valid`=0, all `alu_*`=0 before the next edge, `in_ready`=1.
